// File: rtl/conv_mac_stream_if.sv
// Purpose: tap-input and result-output handshake bundle for conv_mac_stream.
// Ports (signals):
//   in_valid/in_ready   tap handshake; signal (unsigned), weight (signed), bias (signed)
//   out_valid/out_ready result handshake; convout (signed), out_sat (clip flag)
// Modports: master = tap producer / result consumer, slave = conv_mac_stream.
interface conv_mac_stream_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BIAS_W = 8,
  parameter int unsigned OUT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] signal;
  logic [DATA_W-1:0] weight;
  logic [BIAS_W-1:0] bias;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  convout;
  logic              out_sat;

  modport master (
    output in_valid, signal, weight, bias, out_ready,
    input  in_ready, out_valid, convout, out_sat
  );

  modport slave (
    input  in_valid, signal, weight, bias, out_ready,
    output in_ready, out_valid, convout, out_sat
  );
endinterface

// File: rtl/conv_mac_stream.sv
// Purpose: streaming convolution PE. Accumulates KSIZE signal*weight taps per
//   window, adds bias <<< BIAS_SHIFT, shifts right by OUT_SHIFT and saturates to
//   OUT_W signed. A one-entry output register lets the next window accumulate
//   while a result waits for the consumer.
// Ports:
//   clk, reset (async active-high), flush (sync window abort)
//   busy  : window in progress, FINAL pending or result held
//   bus   : conv_mac_stream_if.slave (tap input / result output handshakes)
// Configuration: define CONV_ROUND_EN for round-half-up before the final shift;
//   default build truncates toward -inf.
module conv_mac_stream #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIAS_W     = 8,
  parameter int unsigned KSIZE      = 9,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned BIAS_SHIFT = 6,
  parameter int unsigned OUT_SHIFT  = 9,
  parameter int unsigned OUT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  output logic busy,
  conv_mac_stream_if.slave bus
);

  localparam int unsigned CNT_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KSIZE - 1);
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] OUT_MIN = ~OUT_MAX;
`ifdef CONV_ROUND_EN
  localparam logic signed [SUM_W-1:0] ROUND_ONE = SUM_W'(1) << (OUT_SHIFT - 1);
`endif

  typedef enum logic {S_ACC, S_FINAL} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [BIAS_W-1:0] bias_q, bias_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         convout_q, convout_d;
  logic                     out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0]  sig_ext, wt_ext, product;
  logic signed [SUM_W-1:0]  bias_ext, sum, shifted;
  logic [OUT_W-1:0]         res;
  logic                     res_sat;
  logic                     pop;

  // Unsigned activation times signed weight, both widened first so the product is exact mod 2^ACC_W
  assign sig_ext = {{(ACC_W - DATA_W){1'b0}}, bus.signal};
  assign wt_ext  = {{(ACC_W - DATA_W){bus.weight[DATA_W-1]}}, bus.weight};
  assign product = sig_ext * wt_ext;

  // Final sum carries one extra bit so bias/rounding cannot wrap before the shift
  assign bias_ext = {{(SUM_W - BIAS_W){bias_q[BIAS_W-1]}}, bias_q};
`ifdef CONV_ROUND_EN
  assign sum = {acc_q[ACC_W-1], acc_q} + (bias_ext <<< BIAS_SHIFT) + ROUND_ONE;
`else
  assign sum = {acc_q[ACC_W-1], acc_q} + (bias_ext <<< BIAS_SHIFT);
`endif
  assign shifted = sum >>> OUT_SHIFT;

  // Saturate to OUT_W signed
  always_comb begin
    res     = shifted[OUT_W-1:0];
    res_sat = 1'b0;
    if (shifted > OUT_MAX) begin
      res     = {1'b0, {(OUT_W - 1){1'b1}}};
      res_sat = 1'b1;
    end else if (shifted < OUT_MIN) begin
      res     = {1'b1, {(OUT_W - 1){1'b0}}};
      res_sat = 1'b1;
    end
  end

  assign pop = out_valid_q & bus.out_ready;

  // Next-state: accumulate taps, then one FINAL cycle to load the output register
  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    acc_d       = acc_q;
    bias_d      = bias_q;
    out_valid_d = out_valid_q & ~pop;
    convout_d   = convout_q;
    out_sat_d   = out_sat_q;

    case (state_q)
      S_ACC: begin
        if (bus.in_valid) begin
          acc_d = (tap_cnt_q == '0) ? product : acc_q + product;
          if (tap_cnt_q == LAST_TAP) begin
            tap_cnt_d = '0;
            bias_d    = bus.bias;
            state_d   = S_FINAL;
          end else begin
            tap_cnt_d = tap_cnt_q + CNT_W'(1);
          end
        end
      end
      S_FINAL: begin
        if (!out_valid_q || bus.out_ready) begin
          convout_d   = res;
          out_sat_d   = res_sat;
          out_valid_d = 1'b1;
          state_d     = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase

    // Abort the window; a held result is still delivered, a stalled FINAL is dropped
    if (flush) begin
      tap_cnt_d   = '0;
      acc_d       = '0;
      state_d     = S_ACC;
      out_valid_d = out_valid_q & ~pop;
      convout_d   = convout_q;
      out_sat_d   = out_sat_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_ACC;
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      convout_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      convout_q   <= convout_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.in_ready  = (state_q == S_ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.convout   = convout_q;
  assign bus.out_sat   = out_sat_q;
  assign busy          = (tap_cnt_q != '0) | (state_q == S_FINAL) | out_valid_q;

endmodule

// File: tb/tb_conv_mac_stream.sv
// Purpose: self-checking bench for conv_mac_stream (table of full windows plus
//   directed backpressure, flush, reset and back-to-back sequences).
module tb_conv_mac_stream;

`ifdef CONV_ROUND_EN
  localparam int EXP_A   = 9;   // 9*100*5 + 64
  localparam int EXP_B   = 1;   // 9*10*3
  localparam int EXP_B15 = 16;  // 127<<6 only
`else
  localparam int EXP_A   = 8;
  localparam int EXP_B   = 0;
  localparam int EXP_B15 = 15;
`endif

  logic clk;
  logic reset;
  logic flush;
  logic busy;

  conv_mac_stream_if bus ();

  conv_mac_stream dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sig;
    logic [7:0] wt;
    logic [7:0] bias;
    int         exp_out;
    int         exp_sat;
    string      name;
  } vec_t;

  vec_t vecs[7];
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int conv_i();
    return int'($signed(bus.convout));
  endfunction

  // Called at a negedge; returns at the negedge after the tap transferred
  task automatic send_tap(input logic [7:0] s, input logic [7:0] w, input logic [7:0] b);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.signal   = s;
    bus.weight   = w;
    bus.bias     = b;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL tap_accept_timeout: in_ready stuck low");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_window(input logic [7:0] s, input logic [7:0] w, input logic [7:0] b,
                             input int n);
    for (int i = 0; i < n; i++) send_tap(s, w, b);
  endtask

  // Bounded wait for a result (out_ready assumed high), check it, let it pop
  task automatic expect_result(input string name, input int exp_out, input int exp_sat);
    int guard;
    guard = 0;
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: out_valid never rose", name);
    end else begin
      check({name, "_convout"}, conv_i(), exp_out);
      check({name, "_sat"}, int'(bus.out_sat), exp_sat);
    end
    @(negedge clk);
  endtask

  initial begin
    int iready_low;
    int ovalid_hi;

    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{8'd100, 8'd5,    8'd1,    EXP_A,   0, "pos_bias1"};
    vecs[1] = '{8'd100, 8'hFB,   8'd0,    -9,      0, "neg_weight"};
    vecs[2] = '{8'd255, 8'd127,  8'd0,    127,     1, "sat_max"};
    vecs[3] = '{8'd255, 8'h80,   8'd0,    -128,    1, "sat_min"};
    vecs[4] = '{8'd0,   8'd0,    8'd127,  EXP_B15, 0, "bias_only_pos"};
    vecs[5] = '{8'd0,   8'd0,    8'h80,   -16,     0, "bias_only_neg"};
    vecs[6] = '{8'd200, 8'h9C,   8'd127,  -128,    1, "neg_sat_bias"};

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.signal    = '0;
    bus.weight    = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_convout", conv_i(), 0);
    check("rst_out_sat", int'(bus.out_sat), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // Table: full windows with exact N+2 latency
    for (int v = 0; v < 7; v++) begin
      send_window(vecs[v].sig, vecs[v].wt, vecs[v].bias, 9);
      check({vecs[v].name, "_final_in_ready"}, int'(bus.in_ready), 0);
      check({vecs[v].name, "_final_busy"}, int'(busy), 1);
      check({vecs[v].name, "_early_valid"}, int'(bus.out_valid), 0);
      @(negedge clk);
      check({vecs[v].name, "_valid"}, int'(bus.out_valid), 1);
      check({vecs[v].name, "_convout"}, conv_i(), vecs[v].exp_out);
      check({vecs[v].name, "_sat"}, int'(bus.out_sat), vecs[v].exp_sat);
      @(negedge clk);
      check({vecs[v].name, "_popped"}, int'(bus.out_valid), 0);
    end

    // Backpressure: second window stalls in FINAL behind a held result
    bus.out_ready = 1'b0;
    send_window(8'd100, 8'd5, 8'd1, 9);
    @(negedge clk);
    check("bp_first_valid", int'(bus.out_valid), 1);
    check("bp_first_val", conv_i(), EXP_A);
    send_window(8'd10, 8'd3, 8'd0, 9);
    repeat (3) @(negedge clk);
    check("bp_stall_in_ready", int'(bus.in_ready), 0);
    check("bp_stall_valid", int'(bus.out_valid), 1);
    check("bp_stall_held", conv_i(), EXP_A);
    check("bp_stall_busy", int'(busy), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_reload_valid", int'(bus.out_valid), 1);
    check("bp_reload_val", conv_i(), EXP_B);
    check("bp_reload_sat", int'(bus.out_sat), 0);
    check("bp_reload_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    check("bp_drained", int'(bus.out_valid), 0);

    // Flush mid-window, then a clean window
    send_window(8'd255, 8'd127, 8'd0, 4);
    check("flush_pre_busy", int'(busy), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", int'(busy), 0);
    check("flush_out_valid", int'(bus.out_valid), 0);
    send_window(8'd100, 8'd5, 8'd1, 9);
    expect_result("post_flush", EXP_A, 0);

    // Flush while a result is held: result still delivered, stalled FINAL dropped
    bus.out_ready = 1'b0;
    send_window(8'd100, 8'hFB, 8'd0, 9);
    @(negedge clk);
    send_window(8'd255, 8'd127, 8'd0, 9);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_hold_valid", int'(bus.out_valid), 1);
    check("flush_hold_val", conv_i(), -9);
    check("flush_hold_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("flush_drop_final", int'(bus.out_valid), 0);

    // Reset mid-window
    send_window(8'd255, 8'd127, 8'd0, 5);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_valid", int'(bus.out_valid), 0);
    check("rst_mid_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    send_window(8'd100, 8'd5, 8'd1, 9);
    expect_result("post_rst_mid", EXP_A, 0);

    // Reset during a FINAL stall
    bus.out_ready = 1'b0;
    send_window(8'd255, 8'd127, 8'd0, 9);
    @(negedge clk);
    send_window(8'd100, 8'd5, 8'd1, 9);
    @(negedge clk);
    check("pre_rst_stall_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("rst_stall_busy", int'(busy), 0);
    check("rst_stall_valid", int'(bus.out_valid), 0);
    check("rst_stall_convout", conv_i(), 0);
    check("rst_stall_sat", int'(bus.out_sat), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Back-to-back windows: one result and one in_ready-low cycle per 10 cycles
    iready_low = 0;
    ovalid_hi  = 0;
    bus.in_valid = 1'b1;
    bus.signal   = 8'd100;
    bus.weight   = 8'd5;
    bus.bias     = 8'd1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!bus.in_ready) iready_low++;
      if (bus.out_valid) begin
        ovalid_hi++;
        check("b2b_val", conv_i(), EXP_A);
        check("b2b_period", c % 10, 0);
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_results", ovalid_hi, 4);
    check("b2b_in_ready_low", iready_low, 4);
    repeat (2) @(negedge clk);
    check("end_idle_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
